tacky_regfile_mp: RTL and testbench

Parametrised multi-lane register file for the next-generation tacky core. It generalises the fixed 8 × 17-bit, two-instruction register file to LANES instruction slots per fetch word, with configurable value width and register count. It adds a busy scoreboard so multi-cycle producers (divider, data memory) can claim a destination register and fill it later, and same-cycle write bypass. It sits between decode and the per-lane ALUs, and owns the `pre` register.

---
 rtl/tacky_pkg.sv | 23 ++
 rtl/tacky_popcount.sv | 23 ++
 rtl/tacky_regfile_mp.sv | 133 +++++++++++++
 tb/tb_tacky_regfile_mp.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tacky_pkg.sv
// Shared definitions for the tacky core: type tags, word sizing, opcodes.
package tacky_pkg;

  localparam logic TAG_FLOAT = 1'b1;
  localparam logic TAG_INT   = 1'b0;

  // Legacy field sizes: a stored word is a tag bit over a value field.
  localparam int unsigned REG_SIZE  = 16;
  localparam int unsigned WORD_SIZE = REG_SIZE + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_MUL  = 4'h3,
    OP_DIV  = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_MOV  = 4'h7,
    OP_PRE  = 4'h8
  } opcode_e;

endpackage

// File: rtl/tacky_popcount.sv
// Combinational population count of a bit vector.
module tacky_popcount #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]           bits_i,
  output logic [$clog2(N+1)-1:0] count_c
);

  localparam int unsigned OW = $clog2(N + 1);

  logic [N-1:0] shift;

  // Accumulate the LSB while shifting, so no variable bit index is needed.
  always_comb begin
    count_c = '0;
    shift   = bits_i;
    for (int unsigned i = 0; i < N; i++) begin
      count_c = count_c + OW'(shift[0]);
      shift   = shift >> 1;
    end
  end

endmodule

// File: rtl/tacky_regfile_mp.sv
// Multi-lane register file with busy scoreboard, fill return and write bypass.
module tacky_regfile_mp
  import tacky_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NREGS  = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned PREW   = 8,
  parameter int unsigned BYPASS = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [LANES*$clog2(NREGS)-1:0]       rd_addr,
  output logic [LANES*(WIDTH+1)-1:0]           rd_data,
  output logic [LANES*(WIDTH+1)-1:0]           acc_data,
  output logic [LANES-1:0]                     rd_busy,
  input  logic [LANES-1:0]                     wr_en,
  input  logic [LANES*$clog2(NREGS)-1:0]       wr_addr,
  input  logic [LANES*(WIDTH+1)-1:0]           wr_data,
  input  logic [LANES-1:0]                     claim_en,
  input  logic [LANES*$clog2(NREGS)-1:0]       claim_addr,
  input  logic                                 fill_en,
  input  logic [$clog2(NREGS)-1:0]             fill_addr,
  input  logic [WIDTH:0]                       fill_data,
  input  logic                                 pre_we,
  input  logic [PREW-1:0]                      pre_in,
  output logic [PREW-1:0]                      pre_out,
  output logic [$clog2(NREGS+1)-1:0]           pending,
  output logic                                 wr_conflict
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned PW = $clog2(NREGS + 1);

  logic [DW-1:0]    regs_q [NREGS];
  logic [DW-1:0]    regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [PREW-1:0]  pre_q, pre_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic             conflict_q, conflict_d;

  // Per-address merge: fill lowest, then lanes in program order, claims last.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned a = 0; a < NREGS; a++) begin
      regs_d[a] = regs_q[a];
      if (fill_en && (fill_addr == AW'(a)) && busy_q[AW'(a)]) begin
        regs_d[a]        = fill_data;
        busy_d[AW'(a)]   = 1'b0;
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (wr_en[l] && (wr_addr[l*AW +: AW] == AW'(a))) begin
          regs_d[a]      = wr_data[l*DW +: DW];
          busy_d[AW'(a)] = 1'b0;
        end
      end
      for (int unsigned l = 0; l < LANES; l++) begin
        if (claim_en[l] && (claim_addr[l*AW +: AW] == AW'(a))) begin
          busy_d[AW'(a)] = 1'b1;
        end
      end
    end
  end

  // Flag any pair of lanes writing the same address this cycle.
  always_comb begin
    conflict_d = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // pre holds until explicitly reloaded.
  always_comb begin
    pre_d = pre_q;
    if (pre_we) begin
      pre_d = pre_in;
    end
  end

  tacky_popcount #(.N(NREGS)) u_popcount (
    .bits_i  (busy_d),
    .count_c (pending_d)
  );

  // State registers; reset also drops every outstanding claim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned a = 0; a < NREGS; a++) begin
        regs_q[a] <= '0;
      end
      busy_q     <= '0;
      pre_q      <= '0;
      pending_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < NREGS; a++) begin
        regs_q[a] <= regs_d[a];
      end
      busy_q     <= busy_d;
      pre_q      <= pre_d;
      pending_q  <= pending_d;
      conflict_q <= conflict_d;
    end
  end

  // Read ports: bypass returns the merged next-state word, else the array.
  always_comb begin
    rd_data  = '0;
    acc_data = '0;
    rd_busy  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (BYPASS != 0) begin
        rd_data[l*DW +: DW]  = regs_d[rd_addr[l*AW +: AW]];
        acc_data[l*DW +: DW] = regs_d[l];
      end else begin
        rd_data[l*DW +: DW]  = regs_q[rd_addr[l*AW +: AW]];
        acc_data[l*DW +: DW] = regs_q[l];
      end
      rd_busy[l] = busy_q[rd_addr[l*AW +: AW]] | busy_q[AW'(l)];
    end
  end

  assign pre_out     = pre_q;
  assign pending     = pending_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_tacky_regfile_mp.sv
// Directed bench for tacky_regfile_mp; a BYPASS=0 twin shares the stimulus.
module tb_tacky_regfile_mp;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 17;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    rd_addr;
  logic [1:0]    wr_en;
  logic [5:0]    wr_addr;
  logic [33:0]   wr_data;
  logic [1:0]    claim_en;
  logic [5:0]    claim_addr;
  logic          fill_en;
  logic [2:0]    fill_addr;
  logic [16:0]   fill_data;
  logic          pre_we;
  logic [7:0]    pre_in;

  logic [33:0]   rd_data, acc_data, nb_rd_data, nb_acc_data;
  logic [1:0]    rd_busy, nb_rd_busy;
  logic [7:0]    pre_out, nb_pre_out;
  logic [PW-1:0] pending, nb_pending;
  logic          wr_conflict, nb_wr_conflict;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  tacky_regfile_mp #(.WIDTH(16), .NREGS(8), .LANES(2), .PREW(8), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .acc_data(acc_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .fill_en(fill_en), .fill_addr(fill_addr),
    .fill_data(fill_data), .pre_we(pre_we), .pre_in(pre_in), .pre_out(pre_out),
    .pending(pending), .wr_conflict(wr_conflict)
  );

  tacky_regfile_mp #(.WIDTH(16), .NREGS(8), .LANES(2), .PREW(8), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(nb_rd_data), .acc_data(nb_acc_data),
    .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .fill_en(fill_en), .fill_addr(fill_addr),
    .fill_data(fill_data), .pre_we(pre_we), .pre_in(pre_in), .pre_out(nb_pre_out),
    .pending(nb_pending), .wr_conflict(nb_wr_conflict)
  );

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = '0; claim_addr = '0;
    fill_en = 1'b0; fill_addr = '0; fill_data = '0;
    pre_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int lane, input logic [2:0] a, input logic [16:0] d);
    wr_en[lane] = 1'b1;
    wr_addr[lane*AW +: AW] = a;
    wr_data[lane*DW +: DW] = d;
  endtask

  task automatic drive_claim(input int lane, input logic [2:0] a);
    claim_en[lane] = 1'b1;
    claim_addr[lane*AW +: AW] = a;
  endtask

  task automatic drive_fill(input logic [2:0] a, input logic [16:0] d);
    fill_en = 1'b1; fill_addr = a; fill_data = d;
  endtask

  task automatic set_rd(input int lane, input logic [2:0] a);
    rd_addr[lane*AW +: AW] = a;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); rd_addr = '0; pre_in = '0;
    #12;
    vec_cnt++; if (rd_data !== 34'h0) begin err_cnt++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    vec_cnt++; if (acc_data !== 34'h0) begin err_cnt++; $display("FAIL reset_acc_data got %h exp 0", acc_data); end
    vec_cnt++; if ({rd_busy, pending, wr_conflict, pre_out} !== 15'h0) begin err_cnt++;
      $display("FAIL reset_ctrl busy %b pend %0d conf %b pre %h exp all 0", rd_busy, pending, wr_conflict, pre_out); end
    reset = 1'b1;
    step();
    drive_wr(0, 3'd3, 17'h14000);
    drive_claim(1, 3'd1);
    step();
    idle(); set_rd(0, 3'd3); set_rd(1, 3'd0);
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h14000) begin err_cnt++; $display("FAIL reset_prewrite got %h exp 14000", rd_data[16:0]); end
    vec_cnt++; if (pending !== 4'd1 || rd_busy !== 2'b10) begin err_cnt++;
      $display("FAIL reset_preclaim pend %0d busy %b exp 1 10", pending, rd_busy); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h0) begin err_cnt++; $display("FAIL reset_async_rd got %h exp 0", rd_data[16:0]); end
    vec_cnt++; if (pending !== 4'd0 || rd_busy !== 2'b00) begin err_cnt++;
      $display("FAIL reset_async_busy pend %0d busy %b exp 0 00", pending, rd_busy); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_conflict();
    idle();
    drive_wr(0, 3'd5, 17'h00011);
    drive_wr(1, 3'd5, 17'h00022);
    set_rd(0, 3'd5);
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h00022) begin err_cnt++; $display("FAIL conflict_bypass got %h exp 00022", rd_data[16:0]); end
    step();
    idle();
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h00022) begin err_cnt++; $display("FAIL conflict_value got %h exp 00022", rd_data[16:0]); end
    vec_cnt++; if (wr_conflict !== 1'b1) begin err_cnt++; $display("FAIL conflict_pulse got %b exp 1", wr_conflict); end
    drive_wr(0, 3'd5, 17'h00033);
    drive_wr(1, 3'd6, 17'h00044);
    step();
    idle();
    #1;
    vec_cnt++; if (wr_conflict !== 1'b0) begin err_cnt++; $display("FAIL conflict_clear got %b exp 0", wr_conflict); end
    vec_cnt++; if (nb_rd_data[16:0] !== 17'h00033) begin err_cnt++; $display("FAIL conflict_distinct got %h exp 00033", nb_rd_data[16:0]); end
  endtask

  task automatic test_bypass();
    idle();
    drive_wr(0, 3'd2, 17'h00001);
    step();
    idle();
    drive_wr(0, 3'd2, 17'h13F80);
    set_rd(1, 3'd2);
    #1;
    vec_cnt++; if (rd_data[33:17] !== 17'h13F80) begin err_cnt++; $display("FAIL bypass_on got %h exp 13f80", rd_data[33:17]); end
    vec_cnt++; if (nb_rd_data[33:17] !== 17'h00001) begin err_cnt++; $display("FAIL bypass_off got %h exp 00001", nb_rd_data[33:17]); end
    step();
    idle();
    #1;
    vec_cnt++; if (nb_rd_data[33:17] !== 17'h13F80) begin err_cnt++; $display("FAIL bypass_off_next got %h exp 13f80", nb_rd_data[33:17]); end
  endtask

  task automatic test_claim_fill();
    idle(); set_rd(0, 3'd4); set_rd(1, 3'd0);
    drive_claim(0, 3'd4);
    #1;
    vec_cnt++; if (rd_busy !== 2'b00) begin err_cnt++; $display("FAIL claim_same_cycle busy %b exp 00", rd_busy); end
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy !== 2'b01 || pending !== 4'd1) begin err_cnt++;
      $display("FAIL claim_busy busy %b pend %0d exp 01 1", rd_busy, pending); end
    step(); step();
    drive_fill(3'd4, 17'h00007);
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h00007) begin err_cnt++; $display("FAIL fill_bypass got %h exp 00007", rd_data[16:0]); end
    vec_cnt++; if (nb_rd_data[16:0] !== 17'h00000) begin err_cnt++; $display("FAIL fill_nobypass got %h exp 0", nb_rd_data[16:0]); end
    step();
    idle();
    #1;
    vec_cnt++; if (nb_rd_data[16:0] !== 17'h00007 || rd_busy !== 2'b00 || pending !== 4'd0) begin err_cnt++;
      $display("FAIL fill_done data %h busy %b pend %0d exp 00007 00 0", nb_rd_data[16:0], rd_busy, pending); end
    // accumulator claim stalls lane 1 whatever it reads
    drive_claim(1, 3'd1);
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy !== 2'b10) begin err_cnt++; $display("FAIL acc_busy got %b exp 10", rd_busy); end
    drive_wr(1, 3'd1, 17'h00abc);
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy !== 2'b00 || nb_acc_data[33:17] !== 17'h00abc) begin err_cnt++;
      $display("FAIL acc_write busy %b acc %h exp 00 00abc", rd_busy, nb_acc_data[33:17]); end
    // reset drops the claim, so the late fill is discarded
    drive_claim(0, 3'd3);
    step();
    idle();
    #3 reset = 1'b0;
    #1 reset = 1'b1;
    drive_fill(3'd3, 17'h01234);
    step();
    idle(); set_rd(0, 3'd3);
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h0 || pending !== 4'd0) begin err_cnt++;
      $display("FAIL fill_after_reset data %h pend %0d exp 0 0", rd_data[16:0], pending); end
  endtask

  task automatic test_waw();
    idle(); set_rd(0, 3'd6);
    drive_claim(0, 3'd6);
    step();
    idle();
    #1;
    vec_cnt++; if (pending !== 4'd1 || rd_busy[0] !== 1'b1) begin err_cnt++;
      $display("FAIL waw_claim pend %0d busy %b exp 1 1", pending, rd_busy[0]); end
    drive_wr(1, 3'd6, 17'h00009);
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy[0] !== 1'b0 || pending !== 4'd0 || nb_rd_data[16:0] !== 17'h00009) begin err_cnt++;
      $display("FAIL waw_write busy %b pend %0d data %h exp 0 0 00009", rd_busy[0], pending, nb_rd_data[16:0]); end
    drive_fill(3'd6, 17'h0FFFF);
    #1;
    vec_cnt++; if (rd_data[16:0] !== 17'h00009) begin err_cnt++; $display("FAIL waw_fill_bypass got %h exp 00009", rd_data[16:0]); end
    step();
    idle();
    #1;
    vec_cnt++; if (nb_rd_data[16:0] !== 17'h00009) begin err_cnt++; $display("FAIL waw_fill_discard got %h exp 00009", nb_rd_data[16:0]); end
    // claim plus write in one cycle, with a duplicate claim
    set_rd(0, 3'd7);
    drive_claim(0, 3'd7);
    drive_claim(1, 3'd7);
    drive_wr(0, 3'd7, 17'h00005);
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy[0] !== 1'b1 || pending !== 4'd1 || nb_rd_data[16:0] !== 17'h00005) begin err_cnt++;
      $display("FAIL claim_write busy %b pend %0d data %h exp 1 1 00005", rd_busy[0], pending, nb_rd_data[16:0]); end
    drive_fill(3'd7, 17'h10003);
    step();
    idle();
    #1;
    vec_cnt++; if (rd_busy[0] !== 1'b0 || pending !== 4'd0 || nb_rd_data[16:0] !== 17'h10003) begin err_cnt++;
      $display("FAIL claim_write_fill busy %b pend %0d data %h exp 0 0 10003", rd_busy[0], pending, nb_rd_data[16:0]); end
  endtask

  task automatic test_pre();
    idle();
    pre_we = 1'b1; pre_in = 8'hA5;
    step();
    pre_we = 1'b0; pre_in = 8'h3C;
    for (int i = 0; i < 10; i++) begin
      vec_cnt++; if (pre_out !== 8'hA5) begin err_cnt++; $display("FAIL pre_hold cycle %0d got %h exp a5", i, pre_out); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_bypass();
    test_claim_fill();
    test_waw();
    test_pre();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
